// File: rtl/io_port_pkg.sv
// Shared types and constants for the io_port_responder register block.
// Optional STATUS register is controlled by the IO_PORT_STATUS_EN macro.
package io_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [27:0] OFF_START  = 28'd0;
    localparam logic [27:0] OFF_CTRL   = 28'd1;
    localparam logic [27:0] OFF_STATUS = 28'd2;

    localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;

endpackage

// File: rtl/io_port_regs.sv
// Register file: START, CTRL and (with IO_PORT_STATUS_EN) a read-only STATUS
// register holding a completed-command count; sticky unmapped-address error.
module io_port_regs
    import io_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_done,
    input  logic        cmd_wr,
    input  logic [27:0] offset,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [31:0] start_addr,
    output logic        disp_on,
    output logic        addr_err
);

    logic [31:0] start_q, start_d;
    logic        on_q, on_d;
    logic        err_q, err_d;
    logic        mapped;
`ifdef IO_PORT_STATUS_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        mapped  = (offset == OFF_START) || (offset == OFF_CTRL);
        rd_data = UNMAPPED_RD;
        start_d = start_q;
        on_d    = on_q;
        err_d   = err_q;
`ifdef IO_PORT_STATUS_EN
        mapped  = mapped || (offset == OFF_STATUS);
        cnt_d   = cnt_q;
`endif

        if (offset == OFF_START) begin
            rd_data = start_q;
        end else if (offset == OFF_CTRL) begin
            rd_data = {31'b0, on_q};
`ifdef IO_PORT_STATUS_EN
        end else if (offset == OFF_STATUS) begin
            rd_data = {15'b0, err_q, cnt_q};
`endif
        end

        // Updates land on the edge that closes the response cycle.
        if (cmd_done) begin
            if (cmd_wr && (offset == OFF_START)) start_d = wr_data;
            if (cmd_wr && (offset == OFF_CTRL))  on_d    = wr_data[0];
            if (!mapped)                         err_d   = 1'b1;
`ifdef IO_PORT_STATUS_EN
            cnt_d = cnt_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= '0;
            on_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef IO_PORT_STATUS_EN
            cnt_q   <= '0;
`endif
        end else begin
            start_q <= start_d;
            on_q    <= on_d;
            err_q   <= err_d;
`ifdef IO_PORT_STATUS_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign start_addr = start_q;
    assign disp_on    = on_q;
    assign addr_err   = err_q;

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped IO port responder: captures one command, waits READY_LATENCY
// cycles, pulses mem_ready. STATUS register enabled by IO_PORT_STATUS_EN.
module io_port_responder
    import io_port_pkg::*;
#(
    parameter logic [27:0] BASE_ADDR     = 28'h800_0004,
    parameter int          READY_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_rw,
    input  logic [27:0] mem_data_addr,
    input  logic [31:0] mem_data_wr,
    output logic [31:0] mem_data_rd,
    output logic        mem_ready,
    output logic [31:0] disp_start_addr,
    output logic        disp_on,
    output logic        addr_err,
    output logic [1:0]  dbg_state
);

    // Handshake: initiator holds mem_valid (with stable command) until it sees
    // mem_ready; the responder pulses mem_ready once and then waits for
    // mem_valid to drop before accepting another command.

    localparam logic [3:0] CNT_LOAD = 4'(READY_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [27:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] reg_rd;
    logic [27:0] offset;
    logic        cmd_done;

    // Subtraction is a bijection over 28 bits, so offsets never alias.
    assign offset = addr_q - BASE_ADDR;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        mem_ready = 1'b0;
        cmd_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    rw_d    = mem_rw;
                    addr_d  = mem_data_addr;
                    wdata_d = mem_data_wr;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (!rw_q) rd_d = reg_rd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                mem_ready = 1'b1;
                cmd_done  = 1'b1;
                state_d   = mem_valid ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (!mem_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    io_port_regs u_regs (
        .clk        (clk),
        .rst        (rst),
        .cmd_done   (cmd_done),
        .cmd_wr     (rw_q),
        .offset     (offset),
        .wr_data    (wdata_q),
        .rd_data    (reg_rd),
        .start_addr (disp_start_addr),
        .disp_on    (disp_on),
        .addr_err   (addr_err)
    );

    assign mem_data_rd = rd_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed vector table, reset corner cases and
// randomized commands against a register-level reference model.
module tb_io_port_responder;
    import io_port_pkg::*;

    localparam logic [27:0] BASE = 28'h800_0004;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_rw = 1'b0;
    logic [27:0] mem_data_addr = '0;
    logic [31:0] mem_data_wr = '0;
    logic [31:0] mem_data_rd;
    logic        mem_ready;
    logic [31:0] disp_start_addr;
    logic        disp_on;
    logic        addr_err;
    logic [1:0]  dbg_state;

    io_port_responder #(.BASE_ADDR(BASE), .READY_LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_rw          (mem_rw),
        .mem_data_addr   (mem_data_addr),
        .mem_data_wr     (mem_data_wr),
        .mem_data_rd     (mem_data_rd),
        .mem_ready       (mem_ready),
        .disp_start_addr (disp_start_addr),
        .disp_on         (disp_on),
        .addr_err        (addr_err),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural register contents
    logic [31:0] m_start;
    logic        m_on;
    logic        m_err;
    logic [15:0] m_cnt;
    logic [31:0] m_last_rd;

    typedef struct {
        logic        rw;
        logic [27:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rd;
        logic [31:0] exp_start;
        logic        exp_on;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_mapped(input logic [27:0] a);
`ifdef IO_PORT_STATUS_EN
        return (a == BASE) || (a == BASE + 28'd1) || (a == BASE + 28'd2);
`else
        return (a == BASE) || (a == BASE + 28'd1);
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [27:0] a);
        if (a == BASE) return m_start;
        if (a == BASE + 28'd1) return {31'b0, m_on};
`ifdef IO_PORT_STATUS_EN
        if (a == BASE + 28'd2) return {15'b0, m_err, m_cnt};
`endif
        return 32'h0;
    endfunction

    task automatic model_apply(input logic rw, input logic [27:0] a, input logic [31:0] wd);
        if (rw) begin
            if (a == BASE) m_start = wd;
            else if (a == BASE + 28'd1) m_on = wd[0];
        end else begin
            m_last_rd = model_read(a);
        end
        if (!model_mapped(a)) m_err = 1'b1;
        m_cnt = m_cnt + 16'd1;
    endtask

    task automatic model_reset();
        m_start   = '0;
        m_on      = 1'b0;
        m_err     = 1'b0;
        m_cnt     = '0;
        m_last_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("rst_ready", {31'b0, mem_ready}, 32'h0);
        check("rst_rd", mem_data_rd, 32'h0);
        check("rst_start", disp_start_addr, 32'h0);
        check("rst_on", {31'b0, disp_on}, 32'h0);
        check("rst_err", {31'b0, addr_err}, 32'h0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic drive_cmd(input logic rw, input logic [27:0] a, input logic [31:0] wd);
        @(negedge clk);
        mem_valid     = 1'b1;
        mem_rw        = rw;
        mem_data_addr = a;
        mem_data_wr   = wd;
    endtask

    // Waits from the capture edge through completion; checks against the model.
    task automatic finish_cmd(input logic rw, input logic [27:0] a, input logic [31:0] wd,
                              input int hold, output logic [31:0] rd_seen);
        logic [31:0] exp_rd;
        int lat;
        exp_rd = rw ? m_last_rd : model_read(a);
        @(posedge clk);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (mem_ready === 1'b1 || lat >= 40) break;
        end
        check("latency", lat, LAT + 1);
        rd_seen = mem_data_rd;
        check(rw ? "rd_held_on_write" : "read_data", mem_data_rd, exp_rd);
        model_apply(rw, a, wd);
        if (hold == 0) mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_one_pulse", {31'b0, mem_ready}, 32'h0);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("ready_while_held", {31'b0, mem_ready}, 32'h0);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        check("ready_after_drop", {31'b0, mem_ready}, 32'h0);
        check("start_reg", disp_start_addr, m_start);
        check("disp_on", {31'b0, disp_on}, {31'b0, m_on});
        check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
    endtask

    task automatic run_cmd(input logic rw, input logic [27:0] a, input logic [31:0] wd,
                           input int hold, output logic [31:0] rd_seen);
        drive_cmd(rw, a, wd);
        finish_cmd(rw, a, wd, hold, rd_seen);
    endtask

    initial begin
        logic [31:0] rd;
        model_reset();

        vecs[0] = '{1'b1, BASE,          32'h0100_0000, 1,  32'h0,          32'h0100_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, BASE + 28'd1,  32'h0000_0001, 1,  32'h0,          32'h0100_0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, BASE + 28'd1,  32'h0,         1,  32'h0000_0001,  32'h0100_0000, 1'b1, 1'b0};
        vecs[3] = '{1'b1, BASE + 28'd1,  32'hFFFF_FFFE, 0,  32'h0000_0001,  32'h0100_0000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, BASE + 28'd1,  32'h0,         2,  32'h0,          32'h0100_0000, 1'b0, 1'b0};
        vecs[5] = '{1'b0, BASE,          32'h0,         0,  32'h0100_0000,  32'h0100_0000, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 28'h800_0007,  32'h0,         1,  32'h0,          32'h0100_0000, 1'b0, 1'b1};
        vecs[7] = '{1'b1, BASE,          32'hA5A5_5A5A, 10, 32'h0,          32'hA5A5_5A5A, 1'b0, 1'b1};
        vecs[8] = '{1'b0, BASE,          32'h0,         1,  32'hA5A5_5A5A,  32'hA5A5_5A5A, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 28'h000_0004,  32'hDEAD_BEEF, 1,  32'hA5A5_5A5A,  32'hA5A5_5A5A, 1'b0, 1'b1};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_start", i), disp_start_addr, vecs[i].exp_start);
            check($sformatf("vec%0d_on", i), {31'b0, disp_on}, {31'b0, vecs[i].exp_on});
            check($sformatf("vec%0d_err", i), {31'b0, addr_err}, {31'b0, vecs[i].exp_err});
        end

        // Reset during BUSY aborts the write; held valid is recaptured afterwards.
        do_reset();
        drive_cmd(1'b1, BASE, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'b0, mem_ready}, 32'h0);
        check("abort_start", disp_start_addr, 32'h0);
        check("abort_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        @(negedge clk);
        check("abort_ready_held", {31'b0, mem_ready}, 32'h0);
        check("abort_start_held", disp_start_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        finish_cmd(1'b1, BASE, 32'h1234_5678, 1, rd);
        check("recapture_start", disp_start_addr, 32'h1234_5678);

        // STATUS register after three completed commands.
        do_reset();
        run_cmd(1'b1, BASE + 28'd1, 32'h0, 1, rd);
        run_cmd(1'b1, BASE, 32'h0000_0055, 0, rd);
        run_cmd(1'b1, BASE + 28'd1, 32'h1, 1, rd);
        run_cmd(1'b0, BASE + 28'd2, 32'h0, 1, rd);
`ifdef IO_PORT_STATUS_EN
        check("status_read", rd, 32'h0000_0003);
        check("status_no_err", {31'b0, addr_err}, 32'h0);
        run_cmd(1'b1, BASE + 28'd2, 32'hFFFF_FFFF, 1, rd);
        check("status_wr_no_err", {31'b0, addr_err}, 32'h0);
`else
        check("status_unmapped_rd", rd, 32'h0);
        check("status_unmapped_err", {31'b0, addr_err}, 32'h1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [27:0] a;
            int sel;
            sel = $urandom_range(0, 4);
            a = (sel < 4) ? BASE + 28'(sel) : 28'($urandom);
            run_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
